// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared constants for the data/instruction RAM arbiter.
// - FSM state encodings used by dmem_arbiter
// - BE_WORD: full-word byte enable used for instruction fetches
// - OP_S / OP_I_LOAD: opcode constants shared with the MEM-side wrapper
// - streak_next: saturating increment for the MEM grant streak counter
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_GNT_IF  = 2'd1;
    localparam arb_state_t ST_GNT_MEM = 2'd2;

    localparam logic [3:0] BE_WORD = 4'hF;

    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;

    // Saturating increment: never counts past the limit
    function automatic logic [3:0] streak_next(input logic [3:0] cur,
                                               input logic [3:0] limit);
        if (cur >= limit) begin
            return limit;
        end
        return cur + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// dmem_timeout_ctr
// Clear/enable up-counter with a terminal-count flag.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   i_clr    clear counter to zero (has priority over i_en)
//   i_en     increment counter by one
//   o_tc     high while the count equals TC_VALUE
// ---------------------------------------------------------------------------
module dmem_timeout_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] TC_VALUE = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so a fresh grant always restarts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port RAM between instruction fetch (IF) and the MEM
// stage load/store port. Each access is a req/ack transaction; a stalled
// RAM is aborted after TIMEOUT cycles, and IF is forced a grant after
// MAX_STREAK consecutive MEM grants while IF is waiting.
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   if_req, if_addr                  IF read request (level)
//   if_rdata, if_ready               IF read data / one-cycle completion
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                MEM load/store request (level)
//   mem_rdata, mem_ready             MEM load data / one-cycle completion
//   ram_req, ram_we, ram_addr,
//   ram_wdata, ram_be                registered RAM request
//   ram_rdata, ram_ack               RAM response
//   stall_req                        pipeline stall while a requester waits
//   bus_err                          one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack,
    output logic              stall_req,
    output logic              bus_err
);

    localparam logic [3:0] L_MAX_STREAK = 4'(MAX_STREAK);
    // The abort flag is registered, so it is armed one count early and
    // becomes visible exactly when the counter reaches TIMEOUT-1
    localparam logic [7:0] L_TC_ARM     = 8'(TIMEOUT - 2);

    arb_state_t        r_state;
    logic [3:0]        r_streak;
    logic              r_ram_req;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [3:0]        r_ram_be;
    logic              r_bus_err;

    logic              w_in_gnt;
    logic              w_tc;
    logic              w_mem_win;
    logic              w_done;
    logic [31:0]       w_rdata;

    assign w_in_gnt  = (r_state != ST_IDLE);
    assign w_mem_win = mem_req & (~if_req | (r_streak < L_MAX_STREAK));

    dmem_timeout_ctr #(
        .WIDTH    (8),
        .TC_VALUE (L_TC_ARM)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~w_in_gnt),
        .i_en  (w_in_gnt),
        .o_tc  (w_tc)
    );

    // Arbitration FSM plus the registered RAM request. IDLE always takes one
    // cycle, so a requester that keeps req high is seen as a new access.
    // In IDLE with no MEM grant to a waiting IF, the streak resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_be    <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_win) begin
                        r_state     <= ST_GNT_MEM;
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= mem_we;
                        r_ram_addr  <= mem_addr;
                        r_ram_wdata <= mem_wdata;
                        r_ram_be    <= mem_be;
                        r_streak    <= if_req ? streak_next(r_streak, L_MAX_STREAK) : 4'd0;
                    end else if (if_req) begin
                        r_state     <= ST_GNT_IF;
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= 1'b0;
                        r_ram_addr  <= if_addr;
                        r_ram_wdata <= '0;
                        r_ram_be    <= BE_WORD;
                        r_streak    <= '0;
                    end else begin
                        r_ram_req   <= 1'b0;
                        r_streak    <= '0;
                    end
                end
                ST_GNT_IF, ST_GNT_MEM: begin
                    // An abort in progress ends the access even if an ack
                    // shows up in the same cycle
                    if (ram_ack | r_bus_err) begin
                        r_state   <= ST_IDLE;
                        r_ram_req <= 1'b0;
                    end else if (w_tc) begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ram_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion is combinational so the owner sees ready in the ack cycle.
    // Reset suppresses it so an interrupted access never completes.
    assign w_done    = ~rst & w_in_gnt & (ram_ack | r_bus_err);
    assign w_rdata   = r_bus_err ? 32'h0 : ram_rdata;

    assign if_ready  = w_done & (r_state == ST_GNT_IF);
    assign mem_ready = w_done & (r_state == ST_GNT_MEM);
    assign if_rdata  = if_ready  ? w_rdata : 32'h0;
    assign mem_rdata = mem_ready ? w_rdata : 32'h0;

    assign stall_req = ~rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_be    = r_ram_be;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed checks for dmem_arbiter with hand-computed expectations:
// reset, IF read, delayed store, contention/streak, timeout abort,
// reset mid-access and ack noise while idle.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifReady;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic [31:0] memRdata;
    logic        memReady;
    logic        ramReq;
    logic        ramWe;
    logic [31:0] ramAddr;
    logic [31:0] ramWdata;
    logic [3:0]  ramBe;
    logic [31:0] ramRdata;
    logic        ramAck;
    logic        stallReq;
    logic        busErr;

    int vectorCount = 0;
    int missCount   = 0;

    dmem_arbiter #(
        .ADDR_W     (32),
        .TIMEOUT    (16),
        .MAX_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (ifReq),
        .if_addr   (ifAddr),
        .if_rdata  (ifRdata),
        .if_ready  (ifReady),
        .mem_req   (memReq),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_be    (memBe),
        .mem_rdata (memRdata),
        .mem_ready (memReady),
        .ram_req   (ramReq),
        .ram_we    (ramWe),
        .ram_addr  (ramAddr),
        .ram_wdata (ramWdata),
        .ram_be    (ramBe),
        .ram_rdata (ramRdata),
        .ram_ack   (ramAck),
        .stall_req (stallReq),
        .bus_err   (busErr)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value and log misses
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the requester-side inputs in one go
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic mr, input logic mw,
                                 input logic [31:0] ma, input logic [31:0] md,
                                 input logic [3:0] mb);
        ifReq    = ir;
        ifAddr   = ia;
        memReq   = mr;
        memWe    = mw;
        memAddr  = ma;
        memWdata = md;
        memBe    = mb;
    endtask

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin
        logic expIf;

        rst      = 1'b1;
        ramAck   = 1'b0;
        ramRdata = 32'h0;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_ram_req",   32'(ramReq),   32'h0);
        checkOutput("rst_ram_be",    32'(ramBe),    32'h0);
        checkOutput("rst_stall",     32'(stallReq), 32'h0);
        checkOutput("rst_ready",     32'({ifReady, memReady}), 32'h0);
        checkOutput("rst_bus_err",   32'(busErr),   32'h0);
        checkOutput("rst_state",     32'(dut.r_state), 32'h0);

        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();

        $display("[TB] zero-wait IF read");
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("if_c0_stall",   32'(stallReq), 32'h1);
        checkOutput("if_c0_ram_req", 32'(ramReq),   32'h0);
        nextCycle(); #1;
        checkOutput("if_c1_ram_req", 32'(ramReq),   32'h1);
        checkOutput("if_c1_ram_be",  32'(ramBe),    32'hF);
        checkOutput("if_c1_ram_we",  32'(ramWe),    32'h0);
        checkOutput("if_c1_addr",    ramAddr,       32'h100);
        checkOutput("if_c1_stall",   32'(stallReq), 32'h1);
        checkOutput("if_c1_ready",   32'(ifReady),  32'h0);
        nextCycle();
        ramAck = 1'b1; ramRdata = 32'hDEADBEEF;
        #1;
        checkOutput("if_c2_ready",   32'(ifReady),  32'h1);
        checkOutput("if_c2_rdata",   ifRdata,       32'hDEADBEEF);
        checkOutput("if_c2_memrdy",  32'(memReady), 32'h0);
        checkOutput("if_c2_stall",   32'(stallReq), 32'h0);
        nextCycle();
        ramAck = 1'b0; ramRdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("if_c3_ready",   32'(ifReady),  32'h0);
        checkOutput("if_c3_rdata",   ifRdata,       32'h0);
        checkOutput("if_c3_ram_req", 32'(ramReq),   32'h0);

        $display("[TB] store with three wait cycles");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
        #1;
        checkOutput("st_c0_stall",   32'(stallReq), 32'h1);
        nextCycle(); #1;
        checkOutput("st_c1_ram_req", 32'(ramReq),   32'h1);
        checkOutput("st_c1_ram_we",  32'(ramWe),    32'h1);
        checkOutput("st_c1_addr",    ramAddr,       32'h200);
        checkOutput("st_c1_wdata",   ramWdata,      32'h12345678);
        checkOutput("st_c1_be",      32'(ramBe),    32'h3);
        checkOutput("st_c1_ready",   32'(memReady), 32'h0);
        for (int w = 2; w < 4; w++) begin
            nextCycle(); #1;
            checkOutput("st_wait_req",   32'(ramReq),   32'h1);
            checkOutput("st_wait_wdata", ramWdata,      32'h12345678);
            checkOutput("st_wait_be",    32'(ramBe),    32'h3);
            checkOutput("st_wait_ready", 32'(memReady), 32'h0);
        end
        nextCycle();
        ramAck = 1'b1; ramRdata = 32'h0;
        #1;
        checkOutput("st_ack_ready",  32'(memReady), 32'h1);
        checkOutput("st_ack_rdata",  memRdata,      32'h0);
        checkOutput("st_ack_ifrdy",  32'(ifReady),  32'h0);
        nextCycle();
        ramAck = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("st_post_ready", 32'(memReady), 32'h0);
        checkOutput("st_post_req",   32'(ramReq),   32'h0);

        $display("[TB] contention and streak limit");
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        #1;
        for (int i = 0; i < 5; i++) begin
            expIf = (i == 4);
            nextCycle(); #1;
            checkOutput("ct_owner_addr", ramAddr, expIf ? 32'h104 : 32'h300);
            checkOutput("ct_streak", 32'(dut.r_streak), expIf ? 32'h0 : 32'(i + 1));
            ramAck = 1'b1; ramRdata = 32'hC0DE0000 + 32'(i);
            #1;
            checkOutput("ct_if_ready",  32'(ifReady),  32'(expIf));
            checkOutput("ct_mem_ready", 32'(memReady), 32'(!expIf));
            checkOutput("ct_rdata", expIf ? ifRdata : memRdata, 32'hC0DE0000 + 32'(i));
            checkOutput("ct_other_rdata", expIf ? memRdata : ifRdata, 32'h0);
            checkOutput("ct_stall", 32'(stallReq), 32'h1);
            nextCycle();
            ramAck = 1'b0; ramRdata = 32'h0;
            if (expIf) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            #1;
            checkOutput("ct_idle_req", 32'(ramReq), 32'h0);
        end

        $display("[TB] timeout abort");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        ramRdata = 32'hFFFFFFFF;
        #1;
        nextCycle(); #1;
        for (int k = 1; k < 16; k++) begin
            checkOutput("to_wait", 32'({busErr, memReady}), 32'h0);
            nextCycle(); #1;
        end
        checkOutput("to_bus_err", 32'(busErr),   32'h1);
        checkOutput("to_ready",   32'(memReady), 32'h1);
        checkOutput("to_rdata",   memRdata,      32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ramAck = 1'b1;
        #1;
        checkOutput("to_late_ready", 32'({ifReady, memReady}), 32'h0);
        checkOutput("to_late_err",   32'(busErr), 32'h0);
        checkOutput("to_late_req",   32'(ramReq), 32'h0);
        nextCycle();
        ramAck = 1'b0; ramRdata = 32'h0;

        $display("[TB] reset mid-access");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        #1;
        nextCycle(); #1;
        checkOutput("rm_c1_req",   32'(ramReq), 32'h1);
        checkOutput("rm_c1_state", 32'(dut.r_state), 32'h2);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("rm_rst_ready", 32'(memReady), 32'h0);
        checkOutput("rm_rst_stall", 32'(stallReq), 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ramAck = 1'b1; ramRdata = 32'h55;
        #1;
        checkOutput("rm_post_req",   32'(ramReq), 32'h0);
        checkOutput("rm_post_state", 32'(dut.r_state), 32'h0);
        checkOutput("rm_post_ready", 32'(memReady), 32'h0);
        nextCycle();
        ramAck = 1'b0; ramRdata = 32'h0;
        #1;
        checkOutput("rm_idle_req", 32'(ramReq), 32'h0);

        $display("[TB] ack noise while idle");
        for (int n = 0; n < 2; n++) begin
            ramAck = 1'b1; ramRdata = 32'hAA;
            #1;
            checkOutput("nz_ready", 32'({ifReady, memReady}), 32'h0);
            checkOutput("nz_stall", 32'(stallReq), 32'h0);
            checkOutput("nz_req",   32'(ramReq),   32'h0);
            nextCycle();
        end
        ramAck = 1'b0; ramRdata = 32'h0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
